// File: rtl/skeleton_driver_if.sv
// ----------------------------------------------------------------------------
// skeleton_driver_if.sv
// Bus bundles for skeleton_driver.
//
//   skeleton_driver_host_if : host command / readback side
//     host_en, host_start, host_data          host -> driver
//     host_busy, result_data, result_valid,
//     result_timeout, cycle_count, head_err   driver -> host
//   skeleton_driver_skel_if : skeleton instance side
//     skel_rstn, skel_en, skel_trgg_start_calc,
//     skel_data_in                            driver -> skeleton
//     skel_data_out, skel_data_head,
//     skel_data_valid                         skeleton -> driver
//
// Handshake semantics: host_start is a one-cycle request that is consumed
// only when the driver is idle (host_busy=0) and host_en=1; any start seen
// while busy is dropped, never queued. result_valid and result_timeout are
// single-cycle pulses with no back-pressure; the host must sample them on
// the cycle they are high. skel_data_valid is a level from the skeleton and
// is only honoured while the driver waits for a result.
// ----------------------------------------------------------------------------
interface skeleton_driver_host_if #(
    parameter int BITWIDTH_DATA = 16
);
    logic                     host_en;
    logic                     host_start;
    logic [BITWIDTH_DATA-1:0] host_data;
    logic                     host_busy;
    logic [BITWIDTH_DATA-1:0] result_data;
    logic                     result_valid;
    logic                     result_timeout;
    logic [15:0]              cycle_count;
    logic                     head_err;

    modport master (
        output host_en, host_start, host_data,
        input  host_busy, result_data, result_valid, result_timeout,
               cycle_count, head_err
    );

    modport slave (
        input  host_en, host_start, host_data,
        output host_busy, result_data, result_valid, result_timeout,
               cycle_count, head_err
    );
endinterface

interface skeleton_driver_skel_if #(
    parameter int BITWIDTH_DATA = 16,
    parameter int BITWIDTH_HEAD = 26
);
    logic                     skel_rstn;
    logic                     skel_en;
    logic                     skel_trgg_start_calc;
    logic [BITWIDTH_DATA-1:0] skel_data_in;
    logic [BITWIDTH_DATA-1:0] skel_data_out;
    logic [BITWIDTH_HEAD-1:0] skel_data_head;
    logic                     skel_data_valid;

    modport master (
        output skel_rstn, skel_en, skel_trgg_start_calc, skel_data_in,
        input  skel_data_out, skel_data_head, skel_data_valid
    );

    modport slave (
        input  skel_rstn, skel_en, skel_trgg_start_calc, skel_data_in,
        output skel_data_out, skel_data_head, skel_data_valid
    );
endinterface

// File: rtl/skeleton_driver.sv
// ----------------------------------------------------------------------------
// skeleton_driver.sv
// Host-side driver for skeleton DUTs. Per run it latches one input word,
// pulses the skeleton trigger, waits for the skeleton's valid, then captures
// the output word, the compute latency in WAIT cycles and a header check.
//
// Ports:
//   clk_sys   in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   host      slave modport of skeleton_driver_host_if (commands/results)
//   skel      master modport of skeleton_driver_skel_if (skeleton instance)
//   dbg_state out  current FSM state encoding (IDLE=0 .. CAPT=4)
// ----------------------------------------------------------------------------
module skeleton_driver #(
    parameter int BITWIDTH_DATA  = 16,
    parameter int BITWIDTH_HEAD  = 26,
    parameter int TRIG_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_sys,
    input  logic                   rst,
    skeleton_driver_host_if.slave  host,
    skeleton_driver_skel_if.master skel,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_TRIG  = 3'd2,
        S_WAIT  = 3'd3,
        S_CAPT  = 3'd4
    } state_t;

    // Expected value of both header width fields.
    localparam logic [4:0]  WIDTH_CODE = 5'(BITWIDTH_DATA);
    localparam logic [3:0]  TRIG_LAST  = 4'(TRIG_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t                   state_q;
    state_t                   state_next;
    logic [3:0]               trig_cnt_q;
    logic [15:0]              wait_cnt_q;
    logic [15:0]              wait_cnt_inc;
    logic [BITWIDTH_DATA-1:0] data_in_q;
    logic [BITWIDTH_DATA-1:0] result_data_q;
    logic [15:0]              cycle_count_q;
    logic                     head_err_q;
    logic                     result_timeout_q;
    logic                     skel_rstn_q;
    logic                     skel_en_q;
    logic                     load;
    logic                     capture;
    logic                     timeout_hit;
    logic                     head_ok;

    // Header layout: [25:22] reserved=0, [21:16]=1, [15:10]=1,
    // [9:5] and [4:0] = data width.
    always_comb begin
        head_ok = (skel.skel_data_head[25:22] == 4'd0)
                & (skel.skel_data_head[21:16] == 6'd1)
                & (skel.skel_data_head[15:10] == 6'd1)
                & (skel.skel_data_head[9:5]   == WIDTH_CODE)
                & (skel.skel_data_head[4:0]   == WIDTH_CODE);
    end

    // Value the latency counter takes at the end of this WAIT cycle, so a
    // valid seen in the first WAIT cycle reports a latency of 1.
    always_comb begin
        wait_cnt_inc = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
    end

    always_comb begin
        state_next  = state_q;
        load        = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        if (!host.host_en) begin
            // Disable aborts any run silently.
            state_next = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host.host_start) begin
                        load       = 1'b1;
                        state_next = S_SETUP;
                    end
                end
                S_SETUP: state_next = S_TRIG;
                S_TRIG: begin
                    if (trig_cnt_q == TRIG_LAST) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Valid takes priority over a timeout in the same cycle.
                    if (skel.skel_data_valid) begin
                        capture    = 1'b1;
                        state_next = S_CAPT;
                    end else if (wait_cnt_inc >= TIMEOUT_LIM) begin
                        timeout_hit = 1'b1;
                        state_next  = S_IDLE;
                    end
                end
                S_CAPT:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q          <= S_IDLE;
            trig_cnt_q       <= 4'd0;
            wait_cnt_q       <= 16'd0;
            data_in_q        <= '0;
            result_data_q    <= '0;
            cycle_count_q    <= 16'd0;
            head_err_q       <= 1'b0;
            result_timeout_q <= 1'b0;
            skel_rstn_q      <= 1'b0;
            skel_en_q        <= 1'b0;
        end else begin
            state_q          <= state_next;
            result_timeout_q <= timeout_hit;
            skel_rstn_q      <= 1'b1;
            skel_en_q        <= host.host_en;
            // Counters restart from zero on every entry into their state.
            trig_cnt_q       <= (state_q == S_TRIG) ? trig_cnt_q + 4'd1 : 4'd0;
            wait_cnt_q       <= (state_q == S_WAIT) ? wait_cnt_inc : 16'd0;
            if (load) begin
                data_in_q <= host.host_data;
            end
            if (capture) begin
                result_data_q <= skel.skel_data_out;
                cycle_count_q <= wait_cnt_inc;
                head_err_q    <= ~head_ok;
            end
        end
    end

    assign host.host_busy           = (state_q != S_IDLE);
    assign host.result_data         = result_data_q;
    assign host.result_valid        = (state_q == S_CAPT) & host.host_en;
    assign host.result_timeout      = result_timeout_q;
    assign host.cycle_count         = cycle_count_q;
    assign host.head_err            = head_err_q;

    assign skel.skel_rstn            = skel_rstn_q;
    assign skel.skel_en              = skel_en_q;
    assign skel.skel_trgg_start_calc = (state_q == S_TRIG) & host.host_en;
    assign skel.skel_data_in         = data_in_q;

    assign dbg_state = state_q;

endmodule
